// File: rtl/pl_pkg.sv
// pl_pkg: shared control-bit indices, flag bit positions and FSM encoding for the MEM/WB stage.
package pl_pkg;
    localparam int CTRL_STORE      = 0;
    localparam int CTRL_REG_WR     = 1;
    localparam int CTRL_SAVE_COUT  = 2;
    localparam int CTRL_INV_EXEC   = 3;
    localparam int CTRL_LOAD       = 4;
    localparam int CTRL_INV_FETCH  = 5;
    localparam int CTRL_INV_DECODE = 6;
    localparam int CTRL_CMP_TRUE   = 7;
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_C0    = 2;
    localparam int FLAG_C1    = 1;
    localparam int FLAG_C2    = 0;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_WB        = 2'd2;
endpackage

// File: rtl/pl_flag_reg.sv
// pl_flag_reg: one residue domain's {carry, c0, c1, c2} flags with independent carry/compare enables.
module pl_flag_reg
    import pl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       save_en,
    input  logic       cmp_en,
    input  logic [3:0] flags_in,
    output logic [3:0] flags
);
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags[FLAG_CARRY] <= save_en ? flags_in[FLAG_CARRY] : flags[FLAG_CARRY];
            flags[FLAG_C0:FLAG_C2] <= cmp_en ? flags_in[FLAG_C0:FLAG_C2] : flags[FLAG_C0:FLAG_C2];
        end
    end
endmodule

// File: rtl/pl_memwb_md.sv
// pl_memwb_md: MEM/WB pipeline stage with load wait, one-cycle writeback, flag update and squash counting.
module pl_memwb_md
    import pl_pkg::*;
#(
    parameter int NUM_DOMAINS  = 1,
    parameter int REG_ADDR_WID = 3,
    parameter int CNT_WID      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [NUM_DOMAINS*8-1:0]  ex_result,
    input  logic [REG_ADDR_WID-1:0]   ex_rd,
    input  logic [7:0]                ex_ctrl,
    input  logic [NUM_DOMAINS*4-1:0]  ex_flags,
    input  logic [NUM_DOMAINS*8-1:0]  dmem_dout,
    input  logic                      dmem_rvalid,
    output logic                      mem_wr_en,
    output logic                      invalidate_instr,
    output logic                      reg_wr_en,
    output logic [REG_ADDR_WID-1:0]   wr_addr,
    output logic [NUM_DOMAINS*8-1:0]  wr_data,
    output logic [NUM_DOMAINS*4-1:0]  flags,
    output logic [CNT_WID-1:0]        squash_cnt,
    output logic                      load_busy
);
    logic [1:0]              state;
    logic [REG_ADDR_WID-1:0] pend_rd;
    logic                    pend_wr;
    logic                    accept;
    logic                    take;
    assign invalidate_instr = ex_valid && (ex_ctrl[CTRL_INV_EXEC] || ex_ctrl[CTRL_INV_FETCH] || ex_ctrl[CTRL_INV_DECODE]);
    assign ex_ready  = reset || state != ST_LOAD_WAIT;
    assign accept    = ex_valid && ex_ready;
    assign take      = accept && !invalidate_instr;
    assign mem_wr_en = take && ex_ctrl[CTRL_STORE];
    assign reg_wr_en = state == ST_WB;
    assign load_busy = state == ST_LOAD_WAIT;
    // The load's destination is parked in pend_* so wr_addr/wr_data keep their last value while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            squash_cnt <= '0;
            pend_rd    <= '0;
            pend_wr    <= 1'b0;
        end else begin
            if (accept && invalidate_instr && squash_cnt != '1)
                squash_cnt <= squash_cnt + 1'b1;
            if (state == ST_LOAD_WAIT) begin
                if (dmem_rvalid) begin
                    state <= pend_wr ? ST_WB : ST_IDLE;
                    if (pend_wr) begin
                        wr_addr <= pend_rd;
                        wr_data <= dmem_dout;
                    end
                end
            end else if (take && ex_ctrl[CTRL_LOAD]) begin
                state   <= ST_LOAD_WAIT;
                pend_rd <= ex_rd;
                pend_wr <= ex_ctrl[CTRL_REG_WR];
            end else if (take && ex_ctrl[CTRL_REG_WR]) begin
                state   <= ST_WB;
                wr_addr <= ex_rd;
                wr_data <= ex_result;
            end else begin
                state <= ST_IDLE;
            end
        end
    end
    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        pl_flag_reg u_flag (
            .clk      (clk),
            .reset    (reset),
            .save_en  (take && ex_ctrl[CTRL_SAVE_COUT]),
            .cmp_en   (take && ex_ctrl[CTRL_CMP_TRUE]),
            .flags_in (ex_flags[d*4 +: 4]),
            .flags    (flags[d*4 +: 4])
        );
    end
endmodule

// File: tb/tb_pl_memwb_md.sv
// tb_pl_memwb_md: directed-vector bench for pl_memwb_md with two domains.
module tb_pl_memwb_md;
    localparam logic [7:0] C_ST = 8'h01, C_RW = 8'h02, C_SC = 8'h04, C_IE = 8'h08;
    localparam logic [7:0] C_LD = 8'h10, C_IF = 8'h20, C_ID = 8'h40, C_CT = 8'h80;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_result;
    logic [2:0]  ex_rd;
    logic [7:0]  ex_ctrl;
    logic [7:0]  ex_flags;
    logic [15:0] dmem_dout;
    logic        dmem_rvalid;
    logic        mem_wr_en;
    logic        invalidate_instr;
    logic        reg_wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  flags;
    logic [7:0]  squash_cnt;
    logic        load_busy;
    int n_checks = 0;
    int n_fail = 0;

    pl_memwb_md #(.NUM_DOMAINS(2), .REG_ADDR_WID(3), .CNT_WID(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_result        (ex_result),
        .ex_rd            (ex_rd),
        .ex_ctrl          (ex_ctrl),
        .ex_flags         (ex_flags),
        .dmem_dout        (dmem_dout),
        .dmem_rvalid      (dmem_rvalid),
        .mem_wr_en        (mem_wr_en),
        .invalidate_instr (invalidate_instr),
        .reg_wr_en        (reg_wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .flags            (flags),
        .squash_cnt       (squash_cnt),
        .load_busy        (load_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] r,
                         input logic [2:0] rd, input logic [7:0] f);
        ex_valid = v; ex_ctrl = c; ex_result = r; ex_rd = rd; ex_flags = f;
        #1;
    endtask

    initial begin
        reset = 1'b1; dmem_dout = '0; dmem_rvalid = 1'b0;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        tick; tick;
        drive(1'b1, C_ID | C_ST, 16'h0, 3'd0, 8'h00);
        check("rst_inv", invalidate_instr, 1);
        check("rst_inv_memwr", mem_wr_en, 0);
        check("rst_ready", ex_ready, 1);
        drive(1'b1, C_ST, 16'h0, 3'd0, 8'h00);
        check("rst_memwr", mem_wr_en, 1);
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        tick;
        reset = 1'b0;
        #1;
        check("rst_regwr", reg_wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_flags", flags, 0);
        check("rst_squash", squash_cnt, 0);
        check("rst_busy", load_busy, 0);
        // ALU writeback
        drive(1'b1, C_RW, 16'hA55A, 3'd5, 8'h00);
        check("alu_ready", ex_ready, 1);
        check("alu_memwr", mem_wr_en, 0);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("alu_wren", reg_wr_en, 1);
        check("alu_addr", wr_addr, 5);
        check("alu_data", wr_data, 16'hA55A);
        tick;
        check("alu_wren_off", reg_wr_en, 0);
        check("alu_hold", wr_data, 16'hA55A);
        dmem_rvalid = 1'b1; dmem_dout = 16'hFFFF;
        tick;
        dmem_rvalid = 1'b0;
        check("stray_rvalid_wren", reg_wr_en, 0);
        check("stray_rvalid_data", wr_data, 16'hA55A);
        // load with writeback
        drive(1'b1, C_LD | C_RW, 16'h0, 3'd3, 8'h00);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("ld_ready1", ex_ready, 0);
        check("ld_busy1", load_busy, 1);
        check("ld_hold_data", wr_data, 16'hA55A);
        check("ld_wren1", reg_wr_en, 0);
        tick;
        drive(1'b1, C_RW, 16'hDEAD, 3'd7, 8'h00);
        check("ld_ready2", ex_ready, 0);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        dmem_rvalid = 1'b1; dmem_dout = 16'h1234;
        check("ld_ready3", ex_ready, 0);
        check("ld_wren3", reg_wr_en, 0);
        tick;
        dmem_rvalid = 1'b0;
        check("ld_wren4", reg_wr_en, 1);
        check("ld_data4", wr_data, 16'h1234);
        check("ld_addr4", wr_addr, 3);
        check("ld_ready4", ex_ready, 1);
        tick;
        check("ld_wren5", reg_wr_en, 0);
        // load without reg_wr, combined with store
        drive(1'b1, C_LD | C_ST, 16'h0, 3'd1, 8'h00);
        check("ldst_memwr", mem_wr_en, 1);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("ldst_busy", load_busy, 1);
        dmem_rvalid = 1'b1; dmem_dout = 16'h5555;
        tick;
        dmem_rvalid = 1'b0;
        check("ldnw_wren", reg_wr_en, 0);
        check("ldnw_data", wr_data, 16'h1234);
        check("ldnw_ready", ex_ready, 1);
        // back-to-back ALU ops through WB
        drive(1'b1, C_RW, 16'h1111, 3'd1, 8'h00);
        tick;
        drive(1'b1, C_RW, 16'h2222, 3'd2, 8'h00);
        check("b2b_wren1", reg_wr_en, 1);
        check("b2b_data1", wr_data, 16'h1111);
        check("b2b_ready", ex_ready, 1);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("b2b_wren2", reg_wr_en, 1);
        check("b2b_addr2", wr_addr, 2);
        check("b2b_data2", wr_data, 16'h2222);
        tick;
        check("b2b_wren3", reg_wr_en, 0);
        // flags
        drive(1'b1, C_SC | C_CT, 16'h0, 3'd0, 8'h6B);
        tick;
        check("flg_both", flags, 8'h6B);
        drive(1'b1, C_CT, 16'h0, 3'd0, 8'h94);
        tick;
        check("flg_cmp", flags, 8'h1C);
        drive(1'b1, C_SC, 16'h0, 3'd0, 8'hF0);
        tick;
        check("flg_cout", flags, 8'h94);
        drive(1'b0, C_SC | C_CT, 16'h0, 3'd0, 8'h00);
        tick;
        check("flg_novalid", flags, 8'h94);
        check("inv_novalid", invalidate_instr, 0);
        // squashes
        drive(1'b1, C_ID | C_ST | C_RW | C_SC, 16'hBEEF, 3'd4, 8'hFF);
        check("sq_inv", invalidate_instr, 1);
        check("sq_memwr", mem_wr_en, 0);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("sq_wren", reg_wr_en, 0);
        check("sq_flags", flags, 8'h94);
        check("sq_cnt1", squash_cnt, 1);
        drive(1'b1, C_IE | C_RW, 16'hBEEF, 3'd4, 8'h00);
        tick;
        drive(1'b1, C_IF | C_CT, 16'h0, 3'd0, 8'hFF);
        tick;
        drive(1'b1, C_IE | C_LD, 16'h0, 3'd0, 8'h00);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("sq_ld_busy", load_busy, 0);
        check("sq_cnt4", squash_cnt, 4);
        check("sq_data", wr_data, 16'h2222);
        check("sq_flags2", flags, 8'h94);
        drive(1'b1, C_ID, 16'h0, 3'd0, 8'h00);
        for (int i = 0; i < 300; i++) tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        check("sq_sat", squash_cnt, 8'hFF);
        // reset during load wait
        drive(1'b1, C_LD | C_RW, 16'h0, 3'd6, 8'h00);
        tick;
        drive(1'b0, 8'h00, 16'h0, 3'd0, 8'h00);
        tick;
        reset = 1'b1;
        #1;
        check("rstld_ready", ex_ready, 1);
        tick;
        reset = 1'b0; dmem_rvalid = 1'b1; dmem_dout = 16'h7777;
        #1;
        check("rstld_ready2", ex_ready, 1);
        check("rstld_busy", load_busy, 0);
        tick;
        dmem_rvalid = 1'b0;
        check("rstld_wren", reg_wr_en, 0);
        check("rstld_data", wr_data, 0);
        check("rstld_cnt", squash_cnt, 0);
        tick;
        check("rstld_wren2", reg_wr_en, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
